// File: rtl/sync_arith_driver.sv
// sync_arith_driver: accepts one command at a time, drives it to an external
// arithmetic unit, waits LAT cycles, captures the unit's result and status,
// and holds them as a response until the consumer takes it.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_cmd_valid / o_cmd_ready command handshake (ready only in IDLE)
//   i_cmd_A, i_cmd_B, i_cmd_op command operands and opcode
//   o_arg_A, o_arg_B, o_op    operands/opcode held toward the arithmetic unit
//   i_alu_result, i_alu_status result and {ERROR,NOT_EVEN_ZERO,ZEROS,OVERFLOW}
//   o_rsp_valid / i_rsp_ready response handshake
//   o_rsp_result, o_rsp_status captured response; o_rsp_err = status[3]
//   o_rsp_chk_err             status self-check mismatch
//   o_busy                    high whenever not IDLE
//   o_count                   completed responses, wraps at 256
//
// Optional feature: define PARITY_CHECK_EN to recompute the zero-count parity
// and all-zero flag of the captured result and flag disagreement with the
// unit's status. Without it o_rsp_chk_err is constant 0.
module sync_arith_driver #(
   parameter int unsigned BITS = 32,
   parameter int unsigned OPER = 4,
   parameter int unsigned LAT  = 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_cmd_valid,
   output logic            o_cmd_ready,
   input  logic [BITS-1:0] i_cmd_A,
   input  logic [BITS-1:0] i_cmd_B,
   input  logic [OPER-1:0] i_cmd_op,
   output logic [BITS-1:0] o_arg_A,
   output logic [BITS-1:0] o_arg_B,
   output logic [OPER-1:0] o_op,
   input  logic [BITS-1:0] i_alu_result,
   input  logic [OPER-1:0] i_alu_status,
   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [BITS-1:0] o_rsp_result,
   output logic [OPER-1:0] o_rsp_status,
   output logic            o_rsp_err,
   output logic            o_rsp_chk_err,
   output logic            o_busy,
   output logic [7:0]      o_count
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LAT - 1);
   localparam logic [OPER-1:0]  ERR_STATUS = OPER'(4'b1000);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             illegal_q;
   logic             ready_q;
   logic             busy_q;
   logic [BITS-1:0]  arg_a_q, arg_b_q, rsp_result_q;
   logic [OPER-1:0]  op_q, rsp_status_q;
   logic             rsp_valid_q;
   logic             chk_err_q;
   logic [7:0]       count_q;
   logic             op_legal;
   logic             chk_mismatch;

   // Opcodes with any bit above [1:0] set are not forwarded to the unit.
   assign op_legal = (i_cmd_op[OPER-1:2] == '0);

`ifdef PARITY_CHECK_EN
   logic zero_par;
   logic all_zero;
   // Odd number of zero bits corresponds to NOT_EVEN_ZERO.
   assign zero_par     = ^(~i_alu_result);
   assign all_zero     = (i_alu_result == '0);
   assign chk_mismatch = (zero_par != i_alu_status[2]) || (all_zero != i_alu_status[1]);
`else
   assign chk_mismatch = 1'b0;
`endif

   // Driver FSM with all outputs registered alongside the state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         illegal_q    <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         arg_a_q      <= '0;
         arg_b_q      <= '0;
         op_q         <= '0;
         rsp_result_q <= '0;
         rsp_status_q <= '0;
         rsp_valid_q  <= 1'b0;
         chk_err_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_cmd_valid) begin
                  state_q    <= WAIT;
                  wait_cnt_q <= '0;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  illegal_q  <= !op_legal;
                  if (op_legal) begin
                     arg_a_q <= i_cmd_A;
                     arg_b_q <= i_cmd_B;
                     op_q    <= i_cmd_op;
                  end
               end
            end
            WAIT: begin
               wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               if (illegal_q) begin
                  // Illegal command answers one cycle after acceptance.
                  rsp_result_q <= '0;
                  rsp_status_q <= ERR_STATUS;
                  chk_err_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end else if (wait_cnt_q == LAST_WAIT) begin
                  rsp_result_q <= i_alu_result;
                  rsp_status_q <= i_alu_status;
                  chk_err_q    <= chk_mismatch;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  chk_err_q   <= 1'b0;
                  count_q     <= count_q + 8'd1;
                  ready_q     <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_cmd_ready   = ready_q;
   assign o_busy        = busy_q;
   assign o_arg_A       = arg_a_q;
   assign o_arg_B       = arg_b_q;
   assign o_op          = op_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_result  = rsp_result_q;
   assign o_rsp_status  = rsp_status_q;
   assign o_rsp_err     = rsp_status_q[3];
   assign o_rsp_chk_err = chk_err_q;
   assign o_count       = count_q;

endmodule

// File: tb/tb_sync_arith_driver.sv
// Directed bench for sync_arith_driver (BITS=32, OPER=4, LAT=1).
module tb_sync_arith_driver;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic [31:0] i_cmd_A = '0, i_cmd_B = '0;
   logic [3:0]  i_cmd_op = '0;
   logic [31:0] o_arg_A, o_arg_B;
   logic [3:0]  o_op;
   logic [31:0] i_alu_result = '0;
   logic [3:0]  i_alu_status = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_result;
   logic [3:0]  o_rsp_status;
   logic        o_rsp_err, o_rsp_chk_err, o_busy;
   logic [7:0]  o_count;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef PARITY_CHECK_EN
   localparam logic CHK_ON = 1'b1;
`else
   localparam logic CHK_ON = 1'b0;
`endif

   sync_arith_driver #(.BITS(32), .OPER(4), .LAT(1)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_A(i_cmd_A), .i_cmd_B(i_cmd_B), .i_cmd_op(i_cmd_op),
      .o_arg_A(o_arg_A), .o_arg_B(o_arg_B), .o_op(o_op),
      .i_alu_result(i_alu_result), .i_alu_status(i_alu_status),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status),
      .o_rsp_err(o_rsp_err), .o_rsp_chk_err(o_rsp_chk_err),
      .o_busy(o_busy), .o_count(o_count)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance past the next rising edge; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      logic [115:0] flat;
      #1;
      flat = {o_arg_A, o_arg_B, o_op, o_rsp_result, o_rsp_status, o_count,
              o_rsp_valid, o_rsp_err, o_rsp_chk_err, o_busy};
      n_checks++;
      if (flat !== '0) begin n_fail++; $display("FAIL reset_zero: got %h expected 0", flat); end
      tick(); tick();
      i_reset = 1'b0;
      tick();
      n_checks++;
      if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: ready=%b busy=%b expected ready=1 busy=0", o_cmd_ready, o_busy);
      end
   endtask

   task automatic test_basic();
      i_cmd_A = 32'd5; i_cmd_B = 32'd3; i_cmd_op = 4'h1; i_cmd_valid = 1'b1;
      i_alu_result = 32'h1; i_alu_status = 4'b0100;
      tick();
      i_cmd_valid = 1'b0;
      n_checks++;
      if ({o_arg_A, o_arg_B, o_op} !== {32'd5, 32'd3, 4'h1}) begin
         n_fail++; $display("FAIL basic_args: got A=%h B=%h op=%h expected 5 3 1", o_arg_A, o_arg_B, o_op);
      end
      n_checks++;
      if ({o_busy, o_cmd_ready, o_rsp_valid} !== 3'b100) begin
         n_fail++; $display("FAIL basic_wait: busy/ready/valid=%b expected 100", {o_busy, o_cmd_ready, o_rsp_valid});
      end
      tick();
      n_checks++;
      if ({o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_err, o_rsp_chk_err} !== {1'b1, 32'h1, 4'b0100, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL basic_rsp: valid=%b result=%h status=%b err=%b chk=%b expected 1 1 0100 0 0",
                            o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_err, o_rsp_chk_err);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      n_checks++;
      if ({o_rsp_valid, o_count, o_cmd_ready, o_busy} !== {1'b0, 8'd1, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL basic_done: valid=%b count=%0d ready=%b busy=%b expected 0 1 1 0",
                            o_rsp_valid, o_count, o_cmd_ready, o_busy);
      end
   endtask

   task automatic test_illegal_op();
      i_cmd_A = 32'd7; i_cmd_B = 32'd9; i_cmd_op = 4'h5; i_cmd_valid = 1'b1;
      i_alu_result = 32'hABCD; i_alu_status = 4'b0001;
      tick();
      i_cmd_valid = 1'b0;
      n_checks++;
      if (o_op !== 4'h1) begin n_fail++; $display("FAIL illegal_op_held: got %h expected 1", o_op); end
      tick();
      n_checks++;
      if ({o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_err} !== {1'b1, 32'h0, 4'b1000, 1'b1}) begin
         n_fail++; $display("FAIL illegal_rsp: valid=%b result=%h status=%b err=%b expected 1 0 1000 1",
                            o_rsp_valid, o_rsp_result, o_rsp_status, o_rsp_err);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      n_checks++;
      if (o_count !== 8'd2) begin n_fail++; $display("FAIL illegal_count: got %0d expected 2", o_count); end
   endtask

   task automatic test_parity();
      logic [3:0] st [2];
      logic       exp [2];
      st[0] = 4'b0110; exp[0] = CHK_ON;
      st[1] = 4'b0010; exp[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_cmd_A = 32'd0; i_cmd_B = 32'd0; i_cmd_op = 4'h2; i_cmd_valid = 1'b1;
         i_alu_result = 32'h0; i_alu_status = st[k];
         tick();
         i_cmd_valid = 1'b0;
         tick();
         n_checks++;
         if (o_rsp_valid !== 1'b1 || o_rsp_chk_err !== exp[k]) begin
            n_fail++; $display("FAIL parity_chk[%0d]: valid=%b chk=%b expected 1 %b", k, o_rsp_valid, o_rsp_chk_err, exp[k]);
         end
         i_rsp_ready = 1'b1;
         tick();
         i_rsp_ready = 1'b0;
         n_checks++;
         if (o_rsp_chk_err !== 1'b0) begin n_fail++; $display("FAIL parity_clear[%0d]: got %b expected 0", k, o_rsp_chk_err); end
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      i_cmd_A = 32'd11; i_cmd_B = 32'd1; i_cmd_op = 4'h3; i_cmd_valid = 1'b1;
      i_alu_result = 32'hF; i_alu_status = 4'b0000;
      tick();
      i_cmd_A = 32'd99; i_cmd_op = 4'h0;
      tick();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (!(o_rsp_valid === 1'b1 && o_rsp_result === 32'hF && o_cmd_ready === 1'b0 && o_arg_A === 32'd11 && o_op === 4'h3)) bad++;
         tick();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d bad cycles expected 0", bad); end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      n_checks++;
      if ({o_count, o_cmd_ready, o_arg_A} !== {8'd5, 1'b1, 32'd11}) begin
         n_fail++; $display("FAIL stall_release: count=%0d ready=%b A=%0d expected 5 1 11", o_count, o_cmd_ready, o_arg_A);
      end
      i_alu_result = 32'h3; i_alu_status = 4'b0000;
      tick();
      i_cmd_valid = 1'b0;
      n_checks++;
      if ({o_arg_A, o_op, o_cmd_ready} !== {32'd99, 4'h0, 1'b0}) begin
         n_fail++; $display("FAIL second_issue: A=%0d op=%h ready=%b expected 99 0 0", o_arg_A, o_op, o_cmd_ready);
      end
      tick();
      n_checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_result !== 32'h3) begin
         n_fail++; $display("FAIL second_rsp: valid=%b result=%h expected 1 3", o_rsp_valid, o_rsp_result);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      n_checks++;
      if (o_count !== 8'd6) begin n_fail++; $display("FAIL second_count: got %0d expected 6", o_count); end
   endtask

   task automatic test_reset_mid_wait();
      logic [115:0] flat;
      i_cmd_A = 32'h77; i_cmd_B = 32'h66; i_cmd_op = 4'h1; i_cmd_valid = 1'b1;
      i_alu_result = 32'h55; i_alu_status = 4'b0000;
      tick();
      i_cmd_valid = 1'b0;
      #2;
      i_reset = 1'b1;
      #1;
      flat = {o_arg_A, o_arg_B, o_op, o_rsp_result, o_rsp_status, o_count,
              o_rsp_valid, o_rsp_err, o_rsp_chk_err, o_busy};
      n_checks++;
      if (flat !== '0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", flat); end
      tick();
      i_reset = 1'b0;
      tick(); tick();
      n_checks++;
      if ({o_rsp_valid, o_count, o_cmd_ready} !== {1'b0, 8'd0, 1'b1}) begin
         n_fail++; $display("FAIL reset_drop: valid=%b count=%0d ready=%b expected 0 0 1", o_rsp_valid, o_count, o_cmd_ready);
      end
   endtask

   task automatic test_count_wrap();
      int missing;
      missing = 0;
      i_cmd_op = 4'h0; i_alu_result = 32'h1; i_alu_status = 4'b0100;
      for (int n = 1; n <= 256; n++) begin
         i_cmd_valid = 1'b1;
         tick();
         i_cmd_valid = 1'b0;
         tick();
         if (o_rsp_valid !== 1'b1) missing++;
         i_rsp_ready = 1'b1;
         tick();
         i_rsp_ready = 1'b0;
         if (n == 255) begin
            n_checks++;
            if (o_count !== 8'd255) begin n_fail++; $display("FAIL count_255: got %0d expected 255", o_count); end
         end
      end
      n_checks++;
      if (missing != 0) begin n_fail++; $display("FAIL wrap_rsp: %0d missing responses expected 0", missing); end
      n_checks++;
      if (o_count !== 8'd0) begin n_fail++; $display("FAIL count_wrap: got %0d expected 0", o_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_illegal_op();
      test_parity();
      test_back_to_back();
      test_reset_mid_wait();
      test_count_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_arith_driver.md
SYNC_ARITH_DRIVER -- requirements
Module: sync_arith_driver

Interface
REQ-001 SHALL have parameter BITS, default 32: operand/result width.
REQ-002 SHALL have parameter OPER, default 4: opcode/status width.
REQ-003 SHALL have parameter LAT, default 1: arithmetic-unit result latency in cycles, legal range 1..15.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 i_cmd_valid  in  1  command offered.
REQ-007 o_cmd_ready  out  1  driver accepts a command.
REQ-008 i_cmd_A, i_cmd_B  in  BITS each  command operands.
REQ-009 i_cmd_op  in  OPER  command opcode.
REQ-010 o_arg_A, o_arg_B  out  BITS each  operands driven to the arithmetic unit.
REQ-011 o_op  out  OPER  opcode driven to the arithmetic unit.
REQ-012 i_alu_result  in  BITS  arithmetic-unit result.
REQ-013 i_alu_status  in  OPER  status {ERROR, NOT_EVEN_ZERO, ZEROS, OVERFLOW}, bit 3..0.
REQ-014 o_rsp_valid  out  1  response available.
REQ-015 i_rsp_ready  in  1  response consumed.
REQ-016 o_rsp_result  out  BITS  captured result.
REQ-017 o_rsp_status  out  OPER  captured status.
REQ-018 o_rsp_err  out  1  equals o_rsp_status[3].
REQ-019 o_rsp_chk_err  out  1  status self-check mismatch (see Configuration).
REQ-020 o_busy  out  1  high whenever state is not IDLE.
REQ-021 o_count  out  8  completed-response counter.

Function
REQ-022 SHALL implement FSM states IDLE, WAIT, RESP; o_cmd_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: on i_cmd_valid at edge N with legal opcode (i_cmd_op[OPER-1:2]==0), SHALL register operands/opcode onto o_arg_A/o_arg_B/o_op, clear wait counter, enter WAIT.
REQ-024 o_arg_A/o_arg_B/o_op SHALL hold stable from edge N until the next accepted command.
REQ-025 WAIT: wait counter SHALL increment each edge; at edge N+LAT SHALL capture i_alu_result/i_alu_status into o_rsp_result/o_rsp_status, set o_rsp_valid, enter RESP.
REQ-026 Illegal opcode (any of bits OPER-1..2 set) SHALL be accepted but not driven to o_op; at edge N+1 SHALL present o_rsp_result=0, o_rsp_status=4'b1000, enter RESP.
REQ-027 RESP: o_rsp_valid and response fields SHALL hold until i_rsp_ready; on handshake edge SHALL clear o_rsp_valid, increment o_count, return to IDLE.
REQ-028 o_count SHALL wrap 255 -> 0.
REQ-029 Throughput: at most one command per LAT+2 cycles; i_cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-030 i_reset high SHALL immediately force IDLE; o_arg_A, o_arg_B, o_op, o_rsp_result, o_rsp_status, o_count = 0; o_rsp_valid, o_rsp_err, o_rsp_chk_err, o_busy = 0; o_cmd_ready = 1 after release.
REQ-031 Reset during WAIT or RESP SHALL drop the in-flight operation with no response and no count increment.

Configuration
REQ-032 Macro PARITY_CHECK_EN defined: at capture, driver SHALL recompute zero-count parity and all-zero flag of i_alu_result; o_rsp_chk_err=1 if either mismatches i_alu_status[2] or [1]; held with response, cleared on handshake.
REQ-033 Macro PARITY_CHECK_EN undefined: no check logic; o_rsp_chk_err SHALL be constant 0.

Verification
REQ-034 LAT=1, cmd A=5, B=3, op=4'h1; model returns 32'h1, status 4'b0100 at edge N+1 -> o_rsp_valid at N+1, result 32'h1, err 0, chk_err 0, o_count 1 after handshake.
REQ-035 Cmd op=4'h5 -> o_op unchanged, response at N+1: result 0, status 4'b1000, o_rsp_err 1.
REQ-036 Model returns 32'h0 with status 4'b0110 under PARITY_CHECK_EN -> o_rsp_chk_err 1; same with 4'b0010 -> 0; macro undefined -> always 0.
REQ-037 i_rsp_ready held low 10 cycles, i_cmd_valid high -> response stable, o_cmd_ready 0, no second issue until handshake.
REQ-038 Reset asserted mid-WAIT -> all outputs 0 asynchronously, no response; 256 completed ops -> o_count wraps to 0.
